// File: rtl/mc_ctrl_pkg.sv
// ------------------------------------------------------------------------
// mc_ctrl_pkg: state, opcode/funct and select encodings for mc_control_unit
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that wait on i_memready and are guarded by the timeout counter
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_unit_if.sv
// ------------------------------------------------------------------------
// mc_control_unit_if: datapath <-> control unit strobes and status, Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface mc_control_unit_if;
  logic [5:0] i_op;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_memready;
  logic       o_memread;
  logic       o_memwrite;
  logic       o_instrwrite;
  logic       o_pcen;
  logic       o_regwrite;
  logic       o_regdst;
  logic       o_memtoreg;
  logic       o_iord;
  logic       o_alusrca;
  logic [1:0] o_pcsrc;
  logic [1:0] o_alusrcb;
  logic [2:0] o_alucontrol;
  logic       o_fault;
  logic [3:0] o_state;

  // Datapath / memory side
  modport master (
    output i_op, i_funct, i_zero, i_memready,
    input  o_memread, o_memwrite, o_instrwrite, o_pcen, o_regwrite, o_regdst,
           o_memtoreg, o_iord, o_alusrca, o_pcsrc, o_alusrcb, o_alucontrol,
           o_fault, o_state
  );

  // Control unit side
  modport slave (
    input  i_op, i_funct, i_zero, i_memready,
    output o_memread, o_memwrite, o_instrwrite, o_pcen, o_regwrite, o_regdst,
           o_memtoreg, o_iord, o_alusrca, o_pcsrc, o_alusrcb, o_alucontrol,
           o_fault, o_state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_unit_alu_decoder.sv
// ------------------------------------------------------------------------
// alu_decoder: aluop/funct -> alucontrol with illegal-funct flag, Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            alucontrol = ALU_AND;
            illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ------------------------------------------------------------------------
// mc_control_unit: multicycle MIPS-style Moore control FSM with memory
// wait-state timeout and sticky fault state. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_EXT_ISA  = 1'b1
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  mc_control_unit_if.slave   bus
);

  localparam int             CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  aluop_t           aluop;
  logic [2:0]       dec_alucontrol;
  logic             dec_illegal;

  logic             memread, memwrite, instrwrite, pcen, regwrite;
  logic             regdst, memtoreg, iord, alusrca, fault;
  logic [1:0]       pcsrc, alusrcb;
  logic [2:0]       alucontrol;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.i_funct),
    .alucontrol (dec_alucontrol),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Any state change restarts the count, so every wait state begins at zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (is_wait_state(state) && !bus.i_memready) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  // Ready on the last allowed wait cycle still completes the access
  assign timeout = !bus.i_memready && (wait_cnt == CNT_LAST);

  always_comb begin
    state_nxt  = state;
    aluop      = ALUOP_ADD;
    memread    = 1'b0;
    memwrite   = 1'b0;
    instrwrite = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    fault      = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrcb    = SRCB_B;
    alucontrol = ALU_AND;
    case (state)
      S_FETCH: begin
        memread    = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        if (bus.i_memready) begin
          instrwrite = 1'b1;
          pcen       = 1'b1;
          state_nxt  = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SH;
        alucontrol = ALU_ADD;
        case (bus.i_op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_BNE:       state_nxt = EN_EXT_ISA ? S_BNE    : S_FAULT;
          OP_ADDI:      state_nxt = EN_EXT_ISA ? S_ADDIEX : S_FAULT;
          OP_J:         state_nxt = EN_EXT_ISA ? S_JUMP   : S_FAULT;
          default:      state_nxt = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        state_nxt  = (bus.i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (bus.i_memready) begin
          state_nxt = S_MEMWB;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.i_memready) begin
          state_nxt = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        aluop      = ALUOP_FUNCT;
        alucontrol = dec_alucontrol;
        state_nxt  = dec_illegal ? S_FAULT : S_ALUWB;
      end
      S_ALUWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = (state == S_BEQ) ? bus.i_zero : !bus.i_zero;
        state_nxt  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        state_nxt  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = PCSRC_JUMP;
        pcen      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase
  end

  // State-changing strobes are masked while reset is held
  assign bus.o_memread    = memread;
  assign bus.o_memwrite   = memwrite   & ~i_reset;
  assign bus.o_instrwrite = instrwrite & ~i_reset;
  assign bus.o_pcen       = pcen       & ~i_reset;
  assign bus.o_regwrite   = regwrite   & ~i_reset;
  assign bus.o_regdst     = regdst;
  assign bus.o_memtoreg   = memtoreg;
  assign bus.o_iord       = iord;
  assign bus.o_alusrca    = alusrca;
  assign bus.o_pcsrc      = pcsrc;
  assign bus.o_alusrcb    = alusrcb;
  assign bus.o_alucontrol = alucontrol;
  assign bus.o_fault      = fault;
  assign bus.o_state      = state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ------------------------------------------------------------------------
// tb_mc_control_unit: table-driven instruction vectors plus directed
// wait-state, timeout, ISA-disable and async-reset sequences. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = OP_LW;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memready = 1'b1;

  always #5 clk = ~clk;

  mc_control_unit_if bus0 ();
  mc_control_unit_if bus1 ();

  assign bus0.i_op       = op;
  assign bus0.i_funct    = funct;
  assign bus0.i_zero     = zero;
  assign bus0.i_memready = memready;
  assign bus1.i_op       = op;
  assign bus1.i_funct    = funct;
  assign bus1.i_zero     = zero;
  assign bus1.i_memready = memready;

  mc_control_unit #(.MEM_TIMEOUT(15), .EN_EXT_ISA(1'b1)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0.slave)
  );

  mc_control_unit #(.MEM_TIMEOUT(15), .EN_EXT_ISA(1'b0)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One instruction from FETCH with memory always ready
  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      funct;
    logic            zero;
    logic [2:0]      n;        // number of trail entries
    logic [5:0][3:0] trail;    // expected state per cycle
    logic            chk_alu;
    logic            pcen;     // expected at trail index 2
    logic [1:0]      pcsrc;
    logic [1:0]      srcb;
    logic [2:0]      alu;
    logic [2:0]      wb;       // {regwrite,regdst,memtoreg} at last trail entry
    logic [3:0]      fin;      // state after the trail
  } vec_t;

  vec_t vq[$];

  function automatic logic [5:0][3:0] tr(input state_t a, input state_t b, input state_t c);
    logic [5:0][3:0] t;
    t    = '0;
    t[0] = S_FETCH;
    t[1] = S_DECODE;
    t[2] = a;
    t[3] = b;
    t[4] = c;
    return t;
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [2:0] n, input logic [5:0][3:0] t, input logic ca,
                     input logic pe, input logic [1:0] ps, input logic [1:0] sb,
                     input logic [2:0] al, input logic [2:0] wb, input state_t fn);
    vec_t v;
    v = '{op: o, funct: f, zero: z, n: n, trail: t, chk_alu: ca, pcen: pe,
          pcsrc: ps, srcb: sb, alu: al, wb: wb, fin: fn};
    vq.push_back(v);
  endtask

  initial begin
    vec_t   v;
    int     pulses;
    state_t exp_a [11];
    logic [5:0] ext_ops [3];
    state_t     ext_st  [3];

    // LW/SW/R-types/branches/ADDI/J/illegal
    add(OP_LW,    6'd0,   1'b0, 3'd5, tr(S_MEMADR, S_MEMRD, S_MEMWB), 1'b1, 1'b0, PCSRC_ALU,    SRCB_IMM, ALU_ADD, 3'b101, S_FETCH);
    add(OP_SW,    6'd0,   1'b0, 3'd4, tr(S_MEMADR, S_MEMWR, S_FETCH), 1'b1, 1'b0, PCSRC_ALU,    SRCB_IMM, ALU_ADD, 3'b000, S_FETCH);
    add(OP_RTYPE, FN_ADD, 1'b0, 3'd4, tr(S_EXEC, S_ALUWB, S_FETCH),   1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_ADD, 3'b110, S_FETCH);
    add(OP_RTYPE, FN_SUB, 1'b0, 3'd4, tr(S_EXEC, S_ALUWB, S_FETCH),   1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_SUB, 3'b110, S_FETCH);
    add(OP_RTYPE, FN_AND, 1'b0, 3'd4, tr(S_EXEC, S_ALUWB, S_FETCH),   1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_AND, 3'b110, S_FETCH);
    add(OP_RTYPE, FN_OR,  1'b0, 3'd4, tr(S_EXEC, S_ALUWB, S_FETCH),   1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_OR,  3'b110, S_FETCH);
    add(OP_RTYPE, FN_SLT, 1'b0, 3'd4, tr(S_EXEC, S_ALUWB, S_FETCH),   1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_SLT, 3'b110, S_FETCH);
    add(OP_RTYPE, 6'h3f,  1'b0, 3'd4, tr(S_EXEC, S_FAULT, S_FETCH),   1'b0, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_AND, 3'b000, S_FAULT);
    add(OP_BEQ,   6'd0,   1'b1, 3'd3, tr(S_BEQ, S_FETCH, S_FETCH),    1'b1, 1'b1, PCSRC_ALUOUT, SRCB_B,   ALU_SUB, 3'b000, S_FETCH);
    add(OP_BEQ,   6'd0,   1'b0, 3'd3, tr(S_BEQ, S_FETCH, S_FETCH),    1'b1, 1'b0, PCSRC_ALUOUT, SRCB_B,   ALU_SUB, 3'b000, S_FETCH);
    add(OP_BNE,   6'd0,   1'b1, 3'd3, tr(S_BNE, S_FETCH, S_FETCH),    1'b1, 1'b0, PCSRC_ALUOUT, SRCB_B,   ALU_SUB, 3'b000, S_FETCH);
    add(OP_BNE,   6'd0,   1'b0, 3'd3, tr(S_BNE, S_FETCH, S_FETCH),    1'b1, 1'b1, PCSRC_ALUOUT, SRCB_B,   ALU_SUB, 3'b000, S_FETCH);
    add(OP_ADDI,  6'd0,   1'b0, 3'd4, tr(S_ADDIEX, S_ADDIWB, S_FETCH),1'b1, 1'b0, PCSRC_ALU,    SRCB_IMM, ALU_ADD, 3'b100, S_FETCH);
    add(OP_J,     6'd0,   1'b0, 3'd3, tr(S_JUMP, S_FETCH, S_FETCH),   1'b1, 1'b1, PCSRC_JUMP,   SRCB_B,   ALU_AND, 3'b000, S_FETCH);
    add(6'h3f,    6'd0,   1'b0, 3'd3, tr(S_FAULT, S_FETCH, S_FETCH),  1'b1, 1'b0, PCSRC_ALU,    SRCB_B,   ALU_AND, 3'b000, S_FAULT);

    // Reset state: FETCH outputs present, write strobes masked
    @(negedge clk);
    #1;
    check("rst state",      {28'd0, bus0.o_state}, 32'(S_FETCH));
    check("rst fault",      {31'd0, bus0.o_fault}, 32'd0);
    check("rst memread",    {31'd0, bus0.o_memread}, 32'd1);
    check("rst instrwrite", {31'd0, bus0.o_instrwrite}, 32'd0);
    check("rst pcen",       {31'd0, bus0.o_pcen}, 32'd0);
    check("rst alusrcb",    {30'd0, bus0.o_alusrcb}, 32'(SRCB_FOUR));
    rst = 1'b0;

    foreach (vq[i]) begin
      v = vq[i];
      op = v.op; funct = v.funct; zero = v.zero; memready = 1'b1;
      do_reset();
      for (int k = 0; k < int'(v.n); k++) begin
        #1;
        check($sformatf("v%0d state[%0d]", i, k), {28'd0, bus0.o_state}, {28'd0, v.trail[k]});
        if (k == 2) begin
          check($sformatf("v%0d pcen", i),    {31'd0, bus0.o_pcen},    {31'd0, v.pcen});
          check($sformatf("v%0d pcsrc", i),   {30'd0, bus0.o_pcsrc},   {30'd0, v.pcsrc});
          check($sformatf("v%0d alusrcb", i), {30'd0, bus0.o_alusrcb}, {30'd0, v.srcb});
          if (v.chk_alu)
            check($sformatf("v%0d alucontrol", i), {29'd0, bus0.o_alucontrol}, {29'd0, v.alu});
        end
        if (k == int'(v.n) - 1)
          check($sformatf("v%0d wb", i), {29'd0, bus0.o_regwrite, bus0.o_regdst, bus0.o_memtoreg},
                {29'd0, v.wb});
        @(negedge clk);
      end
      #1;
      check($sformatf("v%0d final", i), {28'd0, bus0.o_state}, {28'd0, v.fin});
      check($sformatf("v%0d fault", i), {31'd0, bus0.o_fault}, {31'd0, (v.fin == S_FAULT)});
    end

    // LW with three wait cycles in both FETCH and MEMRD
    exp_a = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
              S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
    op = OP_LW; memready = 1'b0;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      memready = (k == 3) || (k == 9);
      #1;
      check($sformatf("lw_wait state[%0d]", k), {28'd0, bus0.o_state}, 32'(exp_a[k]));
      if (bus0.o_regwrite) pulses++;
      if (k < 4)
        check($sformatf("lw_wait instrwrite[%0d]", k), {31'd0, bus0.o_instrwrite}, {31'd0, (k == 3)});
      if (k == 10)
        check("lw_wait memtoreg", {31'd0, bus0.o_memtoreg}, 32'd1);
      @(negedge clk);
    end
    #1;
    check("lw_wait final", {28'd0, bus0.o_state}, 32'(S_FETCH));
    check("lw_wait regwrite pulses", 32'(pulses), 32'd1);

    // MEMWR timeout: 15 idle cycles faults; ready on the 15th completes
    for (int p = 0; p < 2; p++) begin
      op = OP_SW; memready = 1'b1;
      do_reset();
      @(negedge clk);
      memready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 1; k <= 15; k++) begin
        memready = (p == 1) && (k == 15);
        #1;
        if (k == 1 || k == 15) begin
          check($sformatf("tmo%0d state[%0d]", p, k), {28'd0, bus0.o_state}, 32'(S_MEMWR));
          check($sformatf("tmo%0d memwrite[%0d]", p, k), {31'd0, bus0.o_memwrite}, 32'd1);
        end
        @(negedge clk);
      end
      #1;
      check($sformatf("tmo%0d after", p), {28'd0, bus0.o_state}, (p == 1) ? 32'(S_FETCH) : 32'(S_FAULT));
      check($sformatf("tmo%0d fault", p), {31'd0, bus0.o_fault}, (p == 1) ? 32'd0 : 32'd1);
    end
    memready = 1'b1;
    op = OP_SW;
    do_reset();
    @(negedge clk);
    memready = 1'b0;
    repeat (20) @(negedge clk);
    memready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("fault absorbing", {28'd0, bus0.o_state}, 32'(S_FAULT));
    check("fault memwrite",  {31'd0, bus0.o_memwrite}, 32'd0);
    check("fault memread",   {31'd0, bus0.o_memread}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("fault async clear", {31'd0, bus0.o_fault}, 32'd0);
    check("fault async state", {28'd0, bus0.o_state}, 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;

    // Extended opcodes fault when the extension is disabled
    ext_ops = '{OP_ADDI, OP_BNE, OP_J};
    ext_st  = '{S_ADDIEX, S_BNE, S_JUMP};
    for (int i = 0; i < 3; i++) begin
      op = ext_ops[i]; memready = 1'b1;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("noext%0d state", i), {28'd0, bus1.o_state}, 32'(S_FAULT));
      check($sformatf("noext%0d fault", i), {31'd0, bus1.o_fault}, 32'd1);
      check($sformatf("ext%0d state", i),   {28'd0, bus0.o_state}, 32'(ext_st[i]));
    end

    // Asynchronous reset in the middle of a stalled MEMRD
    op = OP_LW; memready = 1'b1;
    do_reset();
    @(negedge clk);
    memready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("midrd state", {28'd0, bus0.o_state}, 32'(S_MEMRD));
    memready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrd rst state",      {28'd0, bus0.o_state}, 32'(S_FETCH));
    check("midrd rst fault",      {31'd0, bus0.o_fault}, 32'd0);
    check("midrd rst counter",    32'(dut0.wait_cnt), 32'd0);
    check("midrd rst strobes",    {28'd0, bus0.o_regwrite, bus0.o_memwrite, bus0.o_pcen, bus0.o_instrwrite}, 32'd0);
    check("midrd rst memread",    {31'd0, bus0.o_memread}, 32'd1);
    check("midrd rst iord",       {31'd0, bus0.o_iord}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrd post instrwrite", {31'd0, bus0.o_instrwrite}, 32'd1);
    @(negedge clk);
    #1;
    check("midrd post state", {28'd0, bus0.o_state}, 32'(S_DECODE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait-state cycles per memory access before fault (1..255).
REQ-002 Parameter EN_EXT_ISA, default 1: 1 enables BNE/ADDI/J; 0 treats them as illegal.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-high.
REQ-005 i_op, i_funct  in  6 each  instruction opcode/funct fields from datapath instruction register.
REQ-006 i_zero  in  1  ALU zero flag.
REQ-007 i_memready  in  1  memory completes current read/write this cycle.
REQ-008 o_memread, o_memwrite  out  1 each  memory access request, held until i_memready.
REQ-009 o_instrwrite, o_pcen, o_regwrite, o_regdst, o_memtoreg, o_iord, o_alusrca  out  1 each  datapath strobes/selects.
REQ-010 o_pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 o_alusrcb  out  2  00 B, 01 constant 4, 10 sign-imm, 11 sign-imm<<2.
REQ-012 o_alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-013 o_fault  out  1  sticky fault (illegal opcode or memory timeout).
REQ-014 o_state  out  4  current FSM state encoding, debug only.

Function
REQ-015 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, BNE, ADDIEX, ADDIWB, JUMP, FAULT.
REQ-016 FETCH: iord=0, memread=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; instrwrite=1 and pcen=1 only in the cycle i_memready=1, then DECODE; else stay.
REQ-017 DECODE: alusrca=0, alusrcb=11, alucontrol=010; next by op: 100011/101011->MEMADR, 000000->EXEC, 000100->BEQ, 000101->BNE, 001000->ADDIEX, 000010->JUMP, other->FAULT.
REQ-018 MEMADR: alusrca=1, alusrcb=10, add; op 100011->MEMRD, else MEMWR.
REQ-019 MEMRD: iord=1, memread=1; on i_memready->MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0; ->FETCH.
REQ-020 MEMWR: iord=1, memwrite=1; on i_memready->FETCH.
REQ-021 EXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); other funct->FAULT. ALUWB: regwrite=1, regdst=1, memtoreg=0; ->FETCH.
REQ-022 BEQ: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=i_zero; BNE: same, pcen=!i_zero; both ->FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, add; ADDIWB: regwrite=1, regdst=0, memtoreg=0; ->FETCH.
REQ-024 JUMP: pcsrc=10, pcen=1; ->FETCH.
REQ-025 Wait counter (width clog2(MEM_TIMEOUT+1)) clears on entry to FETCH/MEMRD/MEMWR, increments each cycle i_memready=0; reaching MEM_TIMEOUT with i_memready=0 -> FAULT.
REQ-026 i_memready=1 in the same cycle the counter reaches MEM_TIMEOUT counts as success.
REQ-027 i_memready ignored outside FETCH/MEMRD/MEMWR.
REQ-028 FAULT: all strobes 0, o_fault=1, absorbing until reset.
REQ-029 Outputs not listed for a state are 0 (regwrite, memwrite, pcen never asserted spuriously).

Reset
REQ-030 Reset asserted: state->FETCH, counter->0, o_fault->0 immediately, independent of clock.
REQ-031 During reset all outputs 0 except those FETCH defines combinationally; regwrite/memwrite/pcen/instrwrite forced 0 while i_reset=1.
REQ-032 Reset mid-access aborts the access; first post-reset cycle restarts FETCH with counter 0.

Structure
REQ-033 Package mc_ctrl_pkg: state enum, opcode/funct constants, alucontrol and pcsrc/alusrcb encodings.
REQ-034 Sub-module alu_decoder: combinational funct/aluop -> alucontrol plus illegal-funct flag.

Verification
REQ-035 LW, i_memready delayed 3 cycles in FETCH and MEMRD -> states FETCH(x4),DECODE,MEMADR,MEMRD(x4),MEMWB; one regwrite pulse, memtoreg=1.
REQ-036 BEQ i_zero=1 -> pcen=1 pcsrc=01 in BEQ; BNE i_zero=1 -> pcen=0; BNE i_zero=0 -> pcen=1.
REQ-037 R-type funct 101010 -> alucontrol=111 in EXEC, regdst=1 regwrite=1 in ALUWB; funct 111111 -> FAULT.
REQ-038 i_memready held 0 in MEMWR with MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, o_fault=1, memwrite=0 thereafter; ready on cycle 15 -> FETCH instead.
REQ-039 EN_EXT_ISA=0, op 001000 -> FAULT; EN_EXT_ISA=1 -> ADDIEX,ADDIWB, regdst=0.
REQ-040 Reset asserted mid-MEMRD between clock edges -> state FETCH, o_fault=0, counter 0 before next edge.
